// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared video/game sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;
    localparam int PROJECTILE_COUNT = 4;
endpackage

`default_nettype wire

// File: rtl/archer_projectile_ctl_if.sv
// ============================================================================
// Module      : archer_projectile_ctl_if
// Description : Game-side bus between the frame logic and the projectile ctl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface archer_projectile_ctl_if #(
    parameter int PROJECTILE_COUNT = vga_pkg::PROJECTILE_COUNT
);
    localparam int CNT_W = $clog2(PROJECTILE_COUNT + 1);

    logic                          frame_tick;
    logic                          fire;
    logic [11:0]                   pos_x_archer;
    logic [11:0]                   pos_y_archer;
    logic                          flip_hor_archer;
    logic [1:0]                    game_active;
    logic [1:0]                    char_class;
    logic                          alive;
    logic [11:0]                   target_x;
    logic [11:0]                   target_y;
    logic                          target_active;
    logic [PROJECTILE_COUNT*12-1:0] pos_x_proj;
    logic [PROJECTILE_COUNT*12-1:0] pos_y_proj;
    logic [PROJECTILE_COUNT-1:0]   projectile_animated;
    logic                          proj_hit;
    logic [CNT_W-1:0]              hit_cnt;

    modport master (
        output frame_tick, fire, pos_x_archer, pos_y_archer, flip_hor_archer,
               game_active, char_class, alive, target_x, target_y, target_active,
        input  pos_x_proj, pos_y_proj, projectile_animated, proj_hit, hit_cnt
    );

    modport slave (
        input  frame_tick, fire, pos_x_archer, pos_y_archer, flip_hor_archer,
               game_active, char_class, alive, target_x, target_y, target_active,
        output pos_x_proj, pos_y_proj, projectile_animated, proj_hit, hit_cnt
    );
endinterface

`default_nettype wire

// File: rtl/archer_projectile_ctl.sv
// ============================================================================
// Module      : archer_projectile_ctl
// Description : Archer arrow slots: spawn with cooldown, per-frame flight,
//               screen-edge retirement and target hit detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module archer_projectile_ctl #(
    parameter int PROJECTILE_COUNT = vga_pkg::PROJECTILE_COUNT,
    parameter int PROJ_SPEED       = 6,
    parameter int COOLDOWN_FRAMES  = 20,
    parameter int SCREEN_W         = 1024,
    parameter int TGT_HALF_W       = 32,
    parameter int TGT_HALF_H       = 48
) (
    input  wire logic               clk,
    input  wire logic               rst,
    archer_projectile_ctl_if.slave  bus
);

    localparam int          N           = PROJECTILE_COUNT;
    localparam int          CNT_W       = $clog2(N + 1);
    localparam int          CD_W        = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [11:0] LEFT_LIMIT  = 12'(PROJ_SPEED + 4);
    localparam logic [12:0] RIGHT_LIMIT = 13'(SCREEN_W - 4);
    localparam logic [11:0] STEP        = 12'(PROJ_SPEED);
    localparam logic [12:0] STEP13      = 13'(PROJ_SPEED);
    localparam logic [11:0] HALF_W      = 12'(TGT_HALF_W);
    localparam logic [11:0] HALF_H      = 12'(TGT_HALF_H);

    logic [N-1:0]      active_q, active_d;
    logic [N-1:0]      dir_q, dir_d;
    logic [N*12-1:0]   x_q, x_d;
    logic [N*12-1:0]   y_q, y_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic              hit_q, hit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              enabled;
    logic              free_found;
    logic [N-1:0]      spawn_sel;
    logic [11:0]       px, py, dx, dy;

    assign enabled = (bus.game_active != 2'd0) && (bus.char_class == 2'd2) && bus.alive;

    always_comb begin
        active_d   = active_q;
        dir_d      = dir_q;
        x_d        = x_q;
        y_d        = y_q;
        cd_d       = cd_q;
        hit_d      = 1'b0;
        cnt_d      = '0;
        spawn_sel  = '0;
        free_found = 1'b0;
        px         = '0;
        py         = '0;
        dx         = '0;
        dy         = '0;

        // Free slot is chosen from the pre-tick state so slots retired this tick stay empty.
        for (int i = 0; i < N; i++) begin
            if (!active_q[i] && !free_found) begin
                spawn_sel[i] = 1'b1;
                free_found   = 1'b1;
            end
        end

        if (!enabled) begin
            active_d = '0;
            cd_d     = '0;
        end else if (bus.frame_tick) begin
            for (int i = 0; i < N; i++) begin
                if (active_q[i]) begin
                    px = x_q[i*12 +: 12];
                    py = y_q[i*12 +: 12];
                    dx = (px >= bus.target_x) ? (px - bus.target_x) : (bus.target_x - px);
                    dy = (py >= bus.target_y) ? (py - bus.target_y) : (bus.target_y - py);
                    if (bus.target_active && (dx < HALF_W) && (dy < HALF_H)) begin
                        active_d[i] = 1'b0;
                        cnt_d       = cnt_d + CNT_W'(1);
                    end else if (dir_q[i]) begin
                        if (px < LEFT_LIMIT) begin
                            active_d[i] = 1'b0;
                        end else begin
                            x_d[i*12 +: 12] = px - STEP;
                        end
                    end else begin
                        if (({1'b0, px} + STEP13) > RIGHT_LIMIT) begin
                            active_d[i] = 1'b0;
                        end else begin
                            x_d[i*12 +: 12] = px + STEP;
                        end
                    end
                end
            end

            if (bus.fire && (cd_q == '0) && free_found) begin
                for (int i = 0; i < N; i++) begin
                    if (spawn_sel[i]) begin
                        active_d[i]     = 1'b1;
                        dir_d[i]        = bus.flip_hor_archer;
                        x_d[i*12 +: 12] = bus.pos_x_archer;
                        y_d[i*12 +: 12] = bus.pos_y_archer;
                    end
                end
                cd_d = CD_W'(COOLDOWN_FRAMES);
            end else if (cd_q != '0) begin
                cd_d = cd_q - CD_W'(1);
            end

            hit_d = (cnt_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
            dir_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cd_q     <= '0;
            hit_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cd_q     <= cd_d;
            hit_q    <= hit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.pos_x_proj          = x_q;
    assign bus.pos_y_proj          = y_q;
    assign bus.projectile_animated = active_q;
    assign bus.proj_hit            = hit_q;
    assign bus.hit_cnt             = cnt_q;

endmodule

`default_nettype wire
